shift_unit_n: RTL and testbench



---
 rtl/shift_unit_n.sv | 147 ++++++++++++++
 tb/tb_shift_unit_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_n.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_n
// Brief    : Multi-mode shift register (LSR/ASR/LSL/ROR), one bit per clock,
//            with start/busy/done handshake. Optional serial I/O is enabled
//            by defining SHIFT_UNIT_SERIAL_IO_EN.
// Revision : 1.0
// ============================================================================
module shift_unit_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amount,
`ifdef SHIFT_UNIT_SERIAL_IO_EN
  input  logic              ser_in,
  output logic              ser_out,
`endif
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  q
);

  localparam logic [1:0] C_OP_LSR = 2'b00;
  localparam logic [1:0] C_OP_ASR = 2'b01;
  localparam logic [1:0] C_OP_LSL = 2'b10;
  localparam logic [1:0] C_OP_ROR = 2'b11;

  localparam logic [AMT_W-1:0] C_AMT_ZERO = '0;
  localparam logic [AMT_W-1:0] C_AMT_ONE  = AMT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_zero_pend;
  logic             w_zero_pend_nxt;
  logic             w_fill;
  logic [WIDTH-1:0] w_shifted;

`ifdef SHIFT_UNIT_SERIAL_IO_EN
  logic r_ser_out;
  logic w_out_bit;

  assign w_fill    = ser_in;
  assign w_out_bit = (r_op == C_OP_LSL) ? r_q[WIDTH-1] : r_q[0];
  assign ser_out   = r_ser_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ser_out <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_ser_out <= w_out_bit;
    end
  end
`else
  assign w_fill = 1'b0;
`endif

  // Single-position shift of the current contents using the latched mode.
  always_comb begin
    w_shifted = r_q;
    case (r_op)
      C_OP_LSR: w_shifted = {w_fill, r_q[WIDTH-1:1]};
      C_OP_ASR: w_shifted = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      C_OP_LSL: w_shifted = {r_q[WIDTH-2:0], w_fill};
      C_OP_ROR: w_shifted = {r_q[0], r_q[WIDTH-1:1]};
      default:  w_shifted = r_q;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_q_nxt         = r_q;
    // A zero-amount start completes one edge after it was accepted.
    w_done_nxt      = r_zero_pend;
    w_zero_pend_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_q_nxt = load_value;
        end else if (start) begin
          if (amount == C_AMT_ZERO) begin
            w_zero_pend_nxt = 1'b1;
          end else begin
            w_op_nxt    = op;
            w_cnt_nxt   = amount;
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        w_q_nxt   = w_shifted;
        w_cnt_nxt = r_cnt - C_AMT_ONE;
        if (r_cnt == C_AMT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= C_OP_LSR;
      r_q         <= '0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_q         <= w_q_nxt;
      r_done      <= w_done_nxt;
      r_zero_pend <= w_zero_pend_nxt;
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;
  assign q    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_n
// Brief    : Directed self-checking bench for shift_unit_n (WIDTH=8, AMT_W=3).
// Revision : 1.0
// ============================================================================
module tb_shift_unit_n;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic [1:0] op;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] q;
`ifdef SHIFT_UNIT_SERIAL_IO_EN
  logic       ser_in;
  logic       ser_out;
`endif

  int checks = 0;
  int errors = 0;

  shift_unit_n #(.WIDTH(8), .AMT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .op         (op),
    .amount     (amount),
`ifdef SHIFT_UNIT_SERIAL_IO_EN
    .ser_in     (ser_in),
    .ser_out    (ser_out),
`endif
    .busy       (busy),
    .done       (done),
    .q          (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] o, input logic [2:0] a);
    start = 1'b1; op = o; amount = a;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = 8'h00;
    start = 1'b0; op = 2'b00; amount = 3'd0;
`ifdef SHIFT_UNIT_SERIAL_IO_EN
    ser_in = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    do_load(8'hA5);
    chk("load_q", q, 8'hA5);
    chk("load_busy", busy, 1'b0);
    chk("load_done", done, 1'b0);

    // ASR by 3 from 0x96
    do_load(8'h96);
    do_start(2'b01, 3'd3);
    chk("asr_k_q", q, 8'h96);
    chk("asr_k_busy", busy, 1'b1);
    tick();
    chk("asr_1_q", q, 8'hCB);
    chk("asr_1_busy", busy, 1'b1);
    chk("asr_1_done", done, 1'b0);
    tick();
    chk("asr_2_q", q, 8'hE5);
    chk("asr_2_busy", busy, 1'b1);
    tick();
    chk("asr_3_q", q, 8'hF2);
    chk("asr_3_busy", busy, 1'b0);
    chk("asr_3_done", done, 1'b1);
    tick();
    chk("asr_after_done", done, 1'b0);
    chk("asr_after_q", q, 8'hF2);

    // ROR 1, then back-to-back LSL 2 issued while done is high
    do_load(8'h81);
    do_start(2'b11, 3'd1);
    tick();
    chk("ror_q", q, 8'hC0);
    chk("ror_done", done, 1'b1);
    do_start(2'b10, 3'd2);
    chk("lsl_k_busy", busy, 1'b1);
    tick(); tick();
    chk("lsl_q", q, 8'h00);
    chk("lsl_done", done, 1'b1);

    do_load(8'h81);
    do_start(2'b00, 3'd7);
    for (int i = 0; i < 7; i++) tick();
    chk("lsr7_q", q, 8'h01);
    chk("lsr7_done", done, 1'b1);
    chk("lsr7_busy", busy, 1'b0);

    // amount=0: no busy, done one edge later
    do_load(8'h3C);
    do_start(2'b00, 3'd0);
    chk("zero_k_busy", busy, 1'b0);
    chk("zero_k_done", done, 1'b0);
    tick();
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_q", q, 8'h3C);
    tick();
    chk("zero_done_clr", done, 1'b0);

    // start/load while busy are ignored
    do_load(8'hF0);
    do_start(2'b00, 3'd4);
    tick();
    chk("ign_1_q", q, 8'h78);
    start = 1'b1; load = 1'b1; load_value = 8'h11; op = 2'b10; amount = 3'd1;
    tick();
    start = 1'b0; load = 1'b0;
    chk("ign_2_q", q, 8'h3C);
    tick(); tick();
    chk("ign_q", q, 8'h0F);
    chk("ign_done", done, 1'b1);
    tick();
    chk("ign_no_restart", busy, 1'b0);
    chk("ign_q_hold", q, 8'h0F);

    // reset at the 2nd shift edge
    do_load(8'hF0);
    do_start(2'b00, 3'd4);
    tick();
    chk("rstmid_1_q", q, 8'h78);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_q", q, 8'h00);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmid_no_done", done, 1'b0);
      chk("rstmid_q_hold", q, 8'h00);
    end

`ifdef SHIFT_UNIT_SERIAL_IO_EN
    do_load(8'h00);
    ser_in = 1'b1;
    do_start(2'b00, 3'd2);
    tick(); tick();
    chk("ser_lsr_q", q, 8'hC0);
    chk("ser_lsr_out", ser_out, 1'b0);
    ser_in = 1'b0;
    do_load(8'h80);
    do_start(2'b10, 3'd1);
    tick();
    chk("ser_lsl_q", q, 8'h00);
    chk("ser_lsl_out", ser_out, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
